output_serializer_fifo: RTL and testbench

Parametrised parallel-to-serial output stage with a word FIFO ahead of the shifter. Accepts WIDTH-bit results from the adder datapath, buffers up to DEPTH words plus one in the shifter, and streams them one bit per consumed cycle with a ready/read handshake, selectable bit order and frame marker. It sits between the FP adder result path and the chip's serial output pin logic. It replaces the single-word output register, so the adder no longer stalls while a previous result is still shifting out.

---
 rtl/output_serializer_fifo_if.sv | 28 ++
 rtl/output_serializer_fifo.sv | 89 ++++++++
 tb/tb_output_serializer_fifo.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/output_serializer_fifo_if.sv
// Producer/consumer handshake bundle for the serializer output stage.
// master = adder result path plus serial pin logic, slave = serializer.
interface output_serializer_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 2);

    logic [WIDTH-1:0] parallel_in;
    logic             wr_in;
    logic             output_read_in;
    logic             input_rdy;
    logic             output_rdy;
    logic             serial_out;
    logic             last_out;
    logic [LW-1:0]    level_out;
    logic             ovf_err_out;

    modport master (
        output parallel_in, wr_in, output_read_in,
        input  input_rdy, output_rdy, serial_out, last_out, level_out, ovf_err_out
    );

    modport slave (
        input  parallel_in, wr_in, output_read_in,
        output input_rdy, output_rdy, serial_out, last_out, level_out, ovf_err_out
    );
endinterface

// File: rtl/output_serializer_fifo.sv
// Word FIFO feeding a parallel-to-serial shifter; one bit leaves per consumed
// cycle, with bypass into an idle shifter and gap-free reload at word end.
module output_serializer_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    output_serializer_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam int LW = $clog2(DEPTH + 2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    idx;
    logic             sh_vld;
    logic             ovf;

    logic fifo_full, fifo_empty, pop_bit, word_end, sh_free;
    logic accept, bypass, fifo_push, fifo_pop;

    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign pop_bit    = bus.output_read_in && sh_vld;
    assign word_end   = pop_bit && (idx == IW'(WIDTH - 1));
    assign sh_free    = !sh_vld || word_end;
    assign accept     = bus.wr_in && !fifo_full;
    // An idle (or just-emptied) shifter takes the head of the FIFO first;
    // a new write only skips the FIFO when nothing is queued ahead of it.
    assign fifo_pop   = sh_free && !fifo_empty;
    assign bypass     = accept && fifo_empty && sh_free;
    assign fifo_push  = accept && !bypass;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) begin
                mem[wr_ptr] <= bus.parallel_in;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
            if (fifo_push && !fifo_pop)      count <= count + CW'(1);
            else if (!fifo_push && fifo_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shreg  <= '0;
            idx    <= '0;
            sh_vld <= 1'b0;
        end else if (fifo_pop) begin
            shreg  <= mem[rd_ptr];
            idx    <= '0;
            sh_vld <= 1'b1;
        end else if (bypass) begin
            shreg  <= bus.parallel_in;
            idx    <= '0;
            sh_vld <= 1'b1;
        end else if (word_end) begin
            sh_vld <= 1'b0;
        end else if (pop_bit) begin
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            idx   <= idx + IW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                       ovf <= 1'b0;
        else if (bus.wr_in && fifo_full)   ovf <= 1'b1;
    end

    assign bus.input_rdy   = !fifo_full;
    assign bus.output_rdy  = sh_vld;
    assign bus.serial_out  = sh_vld && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign bus.last_out    = sh_vld && (idx == IW'(WIDTH - 1));
    assign bus.level_out   = LW'(count) + LW'(sh_vld);
    assign bus.ovf_err_out = ovf;
endmodule

// File: tb/tb_output_serializer_fifo.sv
// Bench: LSB-first and MSB-first instances driven in lockstep, checked every
// cycle against a word-queue model plus directed literal expectations.
module tb_output_serializer_fifo;
    localparam int W = 32;
    localparam int D = 4;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic [W-1:0] par = '0;
    logic wr = 1'b0, rd = 1'b0;

    output_serializer_fifo_if #(.WIDTH(W), .DEPTH(D)) i0 ();
    output_serializer_fifo_if #(.WIDTH(W), .DEPTH(D)) i1 ();

    assign i0.parallel_in = par;  assign i1.parallel_in = par;
    assign i0.wr_in = wr;         assign i1.wr_in = wr;
    assign i0.output_read_in = rd; assign i1.output_read_in = rd;

    output_serializer_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0))
        dut0 (.clk_in(clk_in), .rst_in(rst_in), .bus(i0));
    output_serializer_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1))
        dut1 (.clk_in(clk_in), .rst_in(rst_in), .bus(i1));

    always #5 clk_in = ~clk_in;

    logic [1:0] o_irdy, o_ordy, o_ser, o_last, o_ovf;
    logic [2:0] o_lvl [2];
    assign o_irdy = {i1.input_rdy, i0.input_rdy};
    assign o_ordy = {i1.output_rdy, i0.output_rdy};
    assign o_ser  = {i1.serial_out, i0.serial_out};
    assign o_last = {i1.last_out, i0.last_out};
    assign o_ovf  = {i1.ovf_err_out, i0.ovf_err_out};
    assign o_lvl[0] = i0.level_out;
    assign o_lvl[1] = i1.level_out;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: list of held words (front one is shifting), bit position in front word.
    logic [W-1:0] mq[$];
    int  mpos = 0;
    bit  movf = 1'b0;

    initial forever begin
        @(posedge clk_in or negedge rst_in);
        if (!rst_in) begin
            mq.delete(); mpos = 0; movf = 1'b0;
        end else begin
            int  fcnt;
            bit  acc;
            fcnt = (mq.size() > 0) ? mq.size() - 1 : 0;
            acc  = wr && (fcnt != D);
            if (wr && fcnt == D) movf = 1'b1;
            if (rd && mq.size() > 0) begin
                mpos++;
                if (mpos == W) begin mpos = 0; void'(mq.pop_front()); end
            end
            if (acc) mq.push_back(par);
        end
    end

    // Collected output bits per instance.
    logic [159:0] colbits [2];
    int ncol[2], nlast[2], nrdy[2], firstc[2], lastc[2];
    int cyc = 0;

    task automatic clear_col();
        for (int k = 0; k < 2; k++) begin
            colbits[k] = '0; ncol[k] = 0; nlast[k] = 0; nrdy[k] = 0;
            firstc[k] = -1; lastc[k] = -1;
        end
    endtask

    function automatic logic [31:0] word_of(input int k, input int j);
        logic [31:0] w = '0;
        for (int i = 0; i < W; i++)
            if (k == 0) w[i] = colbits[k][j*W+i];
            else        w[W-1-i] = colbits[k][j*W+i];
        return w;
    endfunction

    initial forever begin
        @(negedge clk_in);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int  fc;
            bit  er, es, el;
            fc = (mq.size() > 0) ? mq.size() - 1 : 0;
            er = mq.size() > 0;
            es = er && (k == 0 ? mq[0][mpos] : mq[0][W-1-mpos]);
            el = er && (mpos == W - 1);
            chk($sformatf("output_rdy%0d", k), 32'(o_ordy[k]), 32'(er));
            chk($sformatf("serial_out%0d", k), 32'(o_ser[k]), 32'(es));
            chk($sformatf("last_out%0d", k), 32'(o_last[k]), 32'(el));
            chk($sformatf("level_out%0d", k), 32'(o_lvl[k]), 32'(mq.size()));
            chk($sformatf("input_rdy%0d", k), 32'(o_irdy[k]), 32'(fc != D));
            chk($sformatf("ovf%0d", k), 32'(o_ovf[k]), 32'(movf));
            if (o_ordy[k]) nrdy[k]++;
            if (rd && o_ordy[k] && ncol[k] < 160) begin
                colbits[k][ncol[k]] = o_ser[k];
                ncol[k]++;
                if (o_last[k]) nlast[k]++;
                if (firstc[k] < 0) firstc[k] = cyc;
                lastc[k] = cyc;
            end
        end
    end

    task automatic tick(); @(posedge clk_in); #1; endtask
    task automatic write(input logic [W-1:0] w);
        wr = 1'b1; par = w; tick(); wr = 1'b0;
    endtask
    task automatic do_reset();
        rst_in = 1'b0; wr = 1'b0; rd = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;
        tick();
    endtask

    initial begin
        clear_col();
        do_reset();
        chk("rst_input_rdy", 32'(o_irdy[0]), 32'd1);
        chk("rst_output_rdy", 32'(o_ordy[0]), 32'd0);
        chk("rst_level", 32'(o_lvl[0]), 32'd0);
        chk("rst_ovf", 32'(o_ovf[0]), 32'd0);

        // single word, continuous read
        rd = 1'b1; clear_col();
        write(32'hABCD1110);
        chk("latency_rdy", 32'(o_ordy[0]), 32'd1);
        repeat (40) tick();
        chk("t1_nbits", ncol[0], 32'd32);
        chk("t1_word_lsb", word_of(0, 0), 32'hABCD1110);
        chk("t1_word_msb", word_of(1, 0), 32'hABCD1110);
        chk("t1_rdy_cycles", nrdy[0], 32'd32);
        chk("t1_last_count", nlast[0], 32'd1);

        // MSB-first bit order
        clear_col();
        write(32'h80000001);
        repeat (40) tick();
        chk("t2_first_bit", 32'(colbits[1][0]), 32'd1);
        chk("t2_mid_bits", 32'(colbits[1][30:1]), 32'd0);
        chk("t2_last_bit", 32'(colbits[1][31]), 32'd1);
        chk("t2_word_lsb", word_of(0, 0), 32'h80000001);

        // fill, overflow, drain back-to-back
        rd = 1'b0;
        for (int i = 1; i <= 5; i++) write(32'(i));
        chk("t3_level", 32'(o_lvl[0]), 32'd5);
        chk("t3_input_rdy", 32'(o_irdy[0]), 32'd0);
        write(32'h6);
        chk("t3_ovf", 32'(o_ovf[0]), 32'd1);
        clear_col(); rd = 1'b1;
        repeat (170) tick();
        chk("t3_nbits", ncol[0], 32'd160);
        chk("t3_no_gap", lastc[0] - firstc[0], 32'd159);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("t3_word%0d_lsb", j), word_of(0, j), 32'(j + 1));
            chk($sformatf("t3_word%0d_msb", j), word_of(1, j), 32'(j + 1));
        end
        chk("t3_level_end", 32'(o_lvl[0]), 32'd0);

        // toggled read
        do_reset(); clear_col();
        write(32'hAAAAAAAA);
        for (int i = 0; i < 80; i++) begin rd = ~rd; tick(); end
        rd = 1'b0;
        chk("t4_nbits", ncol[0], 32'd32);
        chk("t4_word_lsb", word_of(0, 0), 32'hAAAAAAAA);
        chk("t4_word_msb", word_of(1, 0), 32'hAAAAAAAA);

        // full FIFO, write on the word-end cycle
        do_reset();
        for (int i = 0; i < 5; i++) write(32'h100 + 32'(i));
        rd = 1'b1;
        repeat (31) tick();
        chk("t5_input_rdy", 32'(o_irdy[0]), 32'd0);
        wr = 1'b1; par = 32'h77; tick(); wr = 1'b0; rd = 1'b0;
        chk("t5_ovf", 32'(o_ovf[0]), 32'd1);
        chk("t5_level", 32'(o_lvl[0]), 32'd4);

        // asynchronous reset mid-word
        do_reset();
        write(32'hF89123DE); write(32'h11111111); write(32'h22222222);
        rd = 1'b1;
        repeat (10) tick();
        rst_in = 1'b0; #1;
        chk("t6_rst_rdy", 32'(o_ordy[0]), 32'd0);
        chk("t6_rst_ser", 32'(o_ser[1]), 32'd0);
        chk("t6_rst_last", 32'(o_last[0]), 32'd0);
        chk("t6_rst_level", 32'(o_lvl[0]), 32'd0);
        chk("t6_rst_irdy", 32'(o_irdy[0]), 32'd1);
        repeat (2) tick();
        rst_in = 1'b1; clear_col();
        repeat (5) tick();
        chk("t6_no_bits", ncol[0], 32'd0);
        write(32'h00000000);
        chk("t6_level", 32'(o_lvl[0]), 32'd1);
        repeat (40) tick();
        chk("t6_nbits", ncol[0], 32'd32);
        chk("t6_word", word_of(0, 0), 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
